// File: rtl/idex_fwd_reg_if.sv
// rtl/idex_fwd_reg_if.sv - ID/EX pipeline register bus: decode side, EX side, back-end status
// master drives decode/status signals, slave is the pipeline register itself.
interface idex_fwd_reg_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    // decode side
    logic            id_valid;
    logic            id_ready;
    logic [6:0]      id_op;
    logic [RA_W-1:0] id_rd;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [XLEN-1:0] id_data1;
    logic [XLEN-1:0] id_data2;
    logic [XLEN-1:0] id_sdata;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;

    // back-end status
    logic [RA_W-1:0] mem_rd;
    logic            mem_reg_write;
    logic            ex_stall;
    logic            flush;

    // EX side
    logic            ex_valid;
    logic [6:0]      ex_op;
    logic [RA_W-1:0] ex_rd;
    logic [XLEN-1:0] ex_data1;
    logic [XLEN-1:0] ex_data2;
    logic [XLEN-1:0] ex_sdata;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [1:0]      forwA;
    logic [1:0]      forwB;
    logic            lu_stall;

    modport master (
        output id_valid, id_op, id_rd, id_rs1, id_rs2,
               id_data1, id_data2, id_sdata,
               id_reg_write, id_mem_read, id_mem_write,
               mem_rd, mem_reg_write, ex_stall, flush,
        input  id_ready, ex_valid, ex_op, ex_rd,
               ex_data1, ex_data2, ex_sdata,
               ex_reg_write, ex_mem_read, ex_mem_write,
               forwA, forwB, lu_stall
    );

    modport slave (
        input  id_valid, id_op, id_rd, id_rs1, id_rs2,
               id_data1, id_data2, id_sdata,
               id_reg_write, id_mem_read, id_mem_write,
               mem_rd, mem_reg_write, ex_stall, flush,
        output id_ready, ex_valid, ex_op, ex_rd,
               ex_data1, ex_data2, ex_sdata,
               ex_reg_write, ex_mem_read, ex_mem_write,
               forwA, forwB, lu_stall
    );
endinterface

// File: rtl/idex_fwd_reg.sv
// rtl/idex_fwd_reg.sv - ID/EX register with forward-select generation and load-use bubble insertion
// Optional IDEX_PERF_CNT_EN adds a saturating stall_cnt of inserted hazard/flush bubbles.
module idex_fwd_reg #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    idex_fwd_reg_if.slave  bus
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]    stall_cnt
`endif
);
    localparam logic [6:0] OP_R_TYPE  = 7'b0110011;
    localparam logic [6:0] OP_S_TYPE  = 7'b0100011;
    localparam logic [6:0] OP_B_TYPE  = 7'b1100011;
    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_J_JAL   = 7'b1101111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_BUBBLE = 1'b1;

    logic [0:0]      state_q,        state_d;
    logic            ex_valid_q,     ex_valid_d;
    logic [6:0]      ex_op_q,        ex_op_d;
    logic [RA_W-1:0] ex_rd_q,        ex_rd_d;
    logic [XLEN-1:0] ex_data1_q,     ex_data1_d;
    logic [XLEN-1:0] ex_data2_q,     ex_data2_d;
    logic [XLEN-1:0] ex_sdata_q,     ex_sdata_d;
    logic            ex_reg_write_q, ex_reg_write_d;
    logic            ex_mem_read_q,  ex_mem_read_d;
    logic            ex_mem_write_q, ex_mem_write_d;
    logic [1:0]      forwA_q,        forwA_d;
    logic [1:0]      forwB_q,        forwB_d;

    logic            use_rs1;
    logic            use_rs2;
    logic            ex_hit_rs1;
    logic            ex_hit_rs2;
    logic            mem_hit_rs1;
    logic            mem_hit_rs2;
    logic            hazard;
    logic            lu_bubble;
    logic            flush_bubble;
    logic            do_hold;
    logic            do_capture;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    always_comb begin
        use_rs1 = !(bus.id_op == OP_U_LUI || bus.id_op == OP_U_AUIPC ||
                    bus.id_op == OP_J_JAL);
        use_rs2 = (bus.id_op == OP_R_TYPE || bus.id_op == OP_S_TYPE ||
                   bus.id_op == OP_B_TYPE);
    end

    // ex_*_q is the instruction that will sit in EX/MEM when the decode
    // instruction reaches EX, so it is the nearer (01) forwarding source.
    always_comb begin
        ex_hit_rs1  = use_rs1 && ex_valid_q && ex_reg_write_q &&
                      (ex_rd_q != '0) && (ex_rd_q == bus.id_rs1);
        ex_hit_rs2  = use_rs2 && ex_valid_q && ex_reg_write_q &&
                      (ex_rd_q != '0) && (ex_rd_q == bus.id_rs2);
        mem_hit_rs1 = use_rs1 && bus.mem_reg_write &&
                      (bus.mem_rd != '0) && (bus.mem_rd == bus.id_rs1);
        mem_hit_rs2 = use_rs2 && bus.mem_reg_write &&
                      (bus.mem_rd != '0) && (bus.mem_rd == bus.id_rs2);
    end

    always_comb begin
        if (ex_hit_rs1)       fwd_a = FWD_EX;
        else if (mem_hit_rs1) fwd_a = FWD_MEM;
        else                  fwd_a = FWD_REG;

        if (ex_hit_rs2)       fwd_b = FWD_EX;
        else if (mem_hit_rs2) fwd_b = FWD_MEM;
        else                  fwd_b = FWD_REG;
    end

    assign hazard = bus.id_valid && ex_mem_read_q && (ex_hit_rs1 || ex_hit_rs2);

    // A bubble in EX never reads memory, so BUBBLE can never re-trigger a hazard.
    always_comb begin
        do_hold      = bus.ex_stall;
        flush_bubble = !bus.ex_stall && bus.flush;
        lu_bubble    = !bus.ex_stall && !bus.flush && (state_q == ST_RUN) && hazard;
        do_capture   = !bus.ex_stall && !bus.flush && !lu_bubble && bus.id_valid;
    end

    always_comb begin
        bus.id_ready = !bus.ex_stall && !bus.flush &&
                       !((state_q == ST_RUN) && hazard);
        bus.lu_stall = lu_bubble;
    end

    always_comb begin
        state_d        = state_q;
        ex_valid_d     = ex_valid_q;
        ex_op_d        = ex_op_q;
        ex_rd_d        = ex_rd_q;
        ex_data1_d     = ex_data1_q;
        ex_data2_d     = ex_data2_q;
        ex_sdata_d     = ex_sdata_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_mem_write_d = ex_mem_write_q;
        forwA_d        = forwA_q;
        forwB_d        = forwB_q;

        if (!do_hold) begin
            state_d        = lu_bubble ? ST_BUBBLE : ST_RUN;
            ex_valid_d     = 1'b0;
            ex_op_d        = '0;
            ex_rd_d        = '0;
            ex_data1_d     = '0;
            ex_data2_d     = '0;
            ex_sdata_d     = '0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_mem_write_d = 1'b0;
            forwA_d        = FWD_REG;
            forwB_d        = FWD_REG;
            if (do_capture) begin
                ex_valid_d     = 1'b1;
                ex_op_d        = bus.id_op;
                ex_rd_d        = bus.id_rd;
                ex_data1_d     = bus.id_data1;
                ex_data2_d     = bus.id_data2;
                ex_sdata_d     = bus.id_sdata;
                ex_reg_write_d = bus.id_reg_write;
                ex_mem_read_d  = bus.id_mem_read;
                ex_mem_write_d = bus.id_mem_write;
                forwA_d        = fwd_a;
                forwB_d        = fwd_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            ex_valid_q     <= 1'b0;
            ex_op_q        <= '0;
            ex_rd_q        <= '0;
            ex_data1_q     <= '0;
            ex_data2_q     <= '0;
            ex_sdata_q     <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            forwA_q        <= FWD_REG;
            forwB_q        <= FWD_REG;
        end else begin
            state_q        <= state_d;
            ex_valid_q     <= ex_valid_d;
            ex_op_q        <= ex_op_d;
            ex_rd_q        <= ex_rd_d;
            ex_data1_q     <= ex_data1_d;
            ex_data2_q     <= ex_data2_d;
            ex_sdata_q     <= ex_sdata_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            forwA_q        <= forwA_d;
            forwB_q        <= forwB_d;
        end
    end

    always_comb begin
        bus.ex_valid     = ex_valid_q;
        bus.ex_op        = ex_op_q;
        bus.ex_rd        = ex_rd_q;
        bus.ex_data1     = ex_data1_q;
        bus.ex_data2     = ex_data2_q;
        bus.ex_sdata     = ex_sdata_q;
        bus.ex_reg_write = ex_reg_write_q;
        bus.ex_mem_read  = ex_mem_read_q;
        bus.ex_mem_write = ex_mem_write_q;
        bus.forwA        = forwA_q;
        bus.forwB        = forwB_q;
    end

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((lu_bubble || flush_bubble) && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_flush_bubble;
    assign unused_flush_bubble = flush_bubble;
`endif
endmodule

// File: tb/tb_idex_fwd_reg.sv
// tb/tb_idex_fwd_reg.sv - directed and random checks of idex_fwd_reg against an EX-contents model
module tb_idex_fwd_reg;
    localparam logic [6:0] R_T  = 7'b0110011;
    localparam logic [6:0] I_T  = 7'b0010011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] S_T  = 7'b0100011;
    localparam logic [6:0] B_T  = 7'b1100011;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] AUI  = 7'b0010111;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    typedef struct packed {
        logic        v;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] d1, d2, sd;
        logic        rw, mr, mw;
        logic [1:0]  fa, fb;
    } ex_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    ex_t  m;
    logic [31:0] m_cnt;
    logic [6:0]  ops [9];

    idex_fwd_reg_if #(.XLEN(32), .RA_W(5)) bus ();

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt;
    idex_fwd_reg #(.XLEN(32), .RA_W(5)) dut (.clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall_cnt));
`else
    idex_fwd_reg #(.XLEN(32), .RA_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic reads_rs1(input logic [6:0] op);
        return !(op inside {LUI, AUI, JAL});
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op inside {R_T, S_T, B_T};
    endfunction

    function automatic logic ex_writes(input logic [4:0] r);
        return m.v && m.rw && (m.rd != 0) && (m.rd == r);
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] r, input logic used);
        if (!used) return 2'b00;
        if (ex_writes(r)) return 2'b01;
        if (bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic rw, input logic mr, input logic mw);
        bus.id_valid = v;     bus.id_op = op;   bus.id_rd = rd;
        bus.id_rs1 = rs1;     bus.id_rs2 = rs2;
        bus.id_data1 = $urandom; bus.id_data2 = $urandom; bus.id_sdata = $urandom;
        bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    endtask

    task automatic check_outputs();
        chk("ex_valid", 32'(bus.ex_valid), 32'(m.v));
        chk("ex_op", 32'(bus.ex_op), 32'(m.op));
        chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
        chk("ex_data1", bus.ex_data1, m.d1);
        chk("ex_data2", bus.ex_data2, m.d2);
        chk("ex_sdata", bus.ex_sdata, m.sd);
        chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
        chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
        chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.mw));
        chk("forwA", 32'(bus.forwA), 32'(m.fa));
        chk("forwB", 32'(bus.forwB), 32'(m.fb));
`ifdef IDEX_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    // One clock: check handshake outputs against the model, advance the model, check EX.
    task automatic cycle();
        logic u1, u2, hz, busy;
        ex_t  nx;
        #1;
        u1   = reads_rs1(bus.id_op);
        u2   = reads_rs2(bus.id_op);
        hz   = bus.id_valid && m.mr && ((u1 && ex_writes(bus.id_rs1)) || (u2 && ex_writes(bus.id_rs2)));
        busy = bus.ex_stall || bus.flush;
        chk("id_ready", 32'(bus.id_ready), 32'(!busy && !hz));
        chk("lu_stall", 32'(bus.lu_stall), 32'(!busy && hz));
        nx = m;
        if (reset) begin
            nx = '0; m_cnt = 0;
        end else if (bus.ex_stall) begin
            nx = m;
        end else if (bus.flush || hz) begin
            nx = '0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (bus.id_valid) begin
            nx.v = 1'b1; nx.op = bus.id_op; nx.rd = bus.id_rd;
            nx.d1 = bus.id_data1; nx.d2 = bus.id_data2; nx.sd = bus.id_sdata;
            nx.rw = bus.id_reg_write; nx.mr = bus.id_mem_read; nx.mw = bus.id_mem_write;
            nx.fa = fwd_of(bus.id_rs1, u1); nx.fb = fwd_of(bus.id_rs2, u2);
        end else begin
            nx = '0;
        end
        @(posedge clk);
        m = nx;
        #1;
        check_outputs();
    endtask

    task automatic quiet();
        set_id(1'b0, 7'd0, 0, 0, 0, 0, 0, 0);
        bus.mem_rd = 0; bus.mem_reg_write = 0; bus.ex_stall = 0; bus.flush = 0;
    endtask

    logic [31:0] cnt_before;
    ex_t         snap;

    initial begin
        ops = '{R_T, I_T, LD, S_T, B_T, LUI, AUI, JAL, JALR};
        m = '0; m_cnt = 0;
        reset = 1'b1;
        quiet();
        @(negedge clk);
        cycle(); cycle();
        chk("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("reset_forwA", 32'(bus.forwA), 32'd0);
        reset = 1'b0;

        // add x5,x1,x2 then sub x6,x5,x7
        set_id(1, R_T, 5, 1, 2, 1, 0, 0); cycle();
        set_id(1, R_T, 6, 5, 7, 1, 0, 0); cycle();
        chk("sub_forwA", 32'(bus.forwA), 32'd1);
        chk("sub_forwB", 32'(bus.forwB), 32'd0);
        set_id(1, R_T, 5, 1, 2, 1, 0, 0); cycle();
        bus.mem_rd = 7; bus.mem_reg_write = 1;
        set_id(1, R_T, 6, 5, 7, 1, 0, 0); cycle();
        chk("sub_mem_forwB", 32'(bus.forwB), 32'd2);

        // EX and MEM both write x5: EX wins
        bus.mem_rd = 5;
        set_id(1, R_T, 5, 1, 2, 1, 0, 0); cycle();
        set_id(1, I_T, 9, 5, 0, 1, 0, 0); cycle();
        chk("prio_forwA", 32'(bus.forwA), 32'd1);
        bus.mem_rd = 0;
        set_id(1, I_T, 0, 0, 0, 1, 0, 0); cycle();
        set_id(1, I_T, 0, 0, 0, 1, 0, 0); cycle();
        chk("x0_forwA", 32'(bus.forwA), 32'd0);

        // lw x5 then sw x5,0(x8)
        quiet();
        cnt_before = m_cnt;
        set_id(1, LD, 5, 1, 0, 1, 1, 0); cycle();
        set_id(1, S_T, 0, 8, 5, 0, 0, 1);
        #1;
        chk("lu_stall_hi", 32'(bus.lu_stall), 32'd1);
        chk("lu_id_ready", 32'(bus.id_ready), 32'd0);
        cycle();
        chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
        bus.mem_rd = 5; bus.mem_reg_write = 1;
        #1;
        chk("lu_single_bubble", 32'(bus.id_ready), 32'd1);
        cycle();
        chk("sw_op", 32'(bus.ex_op), 32'(S_T));
        chk("sw_forwB", 32'(bus.forwB), 32'd2);
        chk("sw_forwA", 32'(bus.forwA), 32'd0);
`ifdef IDEX_PERF_CNT_EN
        chk("cnt_lu", stall_cnt, cnt_before + 1);
`endif

        // flush drops the decode instruction
        quiet();
        set_id(1, R_T, 3, 1, 2, 1, 0, 0); bus.flush = 1; cycle();
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_rw", 32'(bus.ex_reg_write), 32'd0);
        bus.flush = 0; cycle();
        snap = m;
        bus.flush = 1; bus.ex_stall = 1;
        set_id(1, I_T, 4, 3, 0, 1, 0, 0); cycle();
        chk("flush_stall_hold", 32'(bus.ex_rd), 32'(snap.rd));

        // three-cycle back-end stall with add in EX
        bus.flush = 0; bus.ex_stall = 0;
        set_id(1, R_T, 5, 1, 2, 1, 0, 0); cycle();
        snap = m; cnt_before = m_cnt;
        bus.ex_stall = 1;
        set_id(1, R_T, 6, 5, 7, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle();
        chk("stall_data1", bus.ex_data1, snap.d1);
        chk("stall_id_ready", 32'(bus.id_ready), 32'd0);
`ifdef IDEX_PERF_CNT_EN
        chk("cnt_stall", stall_cnt, cnt_before);
`endif

        // reset while in BUBBLE
        quiet();
        set_id(1, LD, 5, 1, 0, 1, 1, 0); cycle();
        set_id(1, R_T, 6, 5, 5, 1, 0, 0); cycle();
        reset = 1; cycle();
        reset = 0;
        #1;
        chk("rst_bub_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_bub_fwd", 32'({bus.forwA, bus.forwB}), 32'd0);
        chk("rst_bub_lu", 32'(bus.lu_stall), 32'd0);
        chk("rst_bub_ready", 32'(bus.id_ready), 32'd1);
        cycle();

        // random traffic over a small register set to provoke matches
        for (int n = 0; n < 600; n++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 8)];
            set_id($urandom_range(0, 3) != 0, op, 5'($urandom_range(0, 5)),
                   5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                   $urandom_range(0, 1), op == LD, op == S_T);
            bus.mem_rd        = 5'($urandom_range(0, 5));
            bus.mem_reg_write = $urandom_range(0, 1);
            bus.ex_stall      = $urandom_range(0, 7) == 0;
            bus.flush         = $urandom_range(0, 9) == 0;
            reset             = $urandom_range(0, 63) == 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
